// File: rtl/contador_nbits_rco_if.sv
// Bus bundle for contador_nbits_rco.
//   master : drives enb, modo, D; observes Q, RCO, ovf (bench / parent block)
//   slave  : the counter itself
// Signals:
//   enb  - count/load enable
//   modo - 00 up, 01 down, 10 down by 3, 11 parallel load
//   D    - parallel load value (W bits)
//   Q    - registered count (W bits)
//   RCO  - registered per-slice carry/borrow pulse (NIBBLES bits)
//   ovf  - sticky full-counter wrap flag
interface contador_nbits_rco_if #(
  parameter int NIBBLES = 4,
  parameter int SLICE_W = 4
);
  localparam int W = NIBBLES * SLICE_W;

  logic               enb;
  logic [1:0]         modo;
  logic [W-1:0]       D;
  logic [W-1:0]       Q;
  logic [NIBBLES-1:0] RCO;
  logic               ovf;

  modport master (output enb, modo, D, input  Q, RCO, ovf);
  modport slave  (input  enb, modo, D, output Q, RCO, ovf);
endinterface

// File: rtl/contador_nbits_rco.sv
// contador_nbits_rco: NIBBLES x SLICE_W bit up/down/down-by-3/load counter
// with a registered per-slice ripple-carry-out pulse and a sticky wrap flag.
//   clk     - rising-edge clock
//   reset_L - asynchronous, active-low reset (clears Q, RCO, ovf)
//   bus     - contador_nbits_rco_if.slave (enb, modo, D in; Q, RCO, ovf out)
// Optional: define CONTADOR_SATURATE_EN to clamp Q instead of wrapping.
// RCO and ovf are identical in both builds; only Q differs.

// Carry/borrow detect for one slice. l is the whole low part of Q up to
// and including this slice, so the flags come out thermometer-shaped.
module contador_rco_slice #(
  parameter int LW = 4
) (
  input  logic [LW-1:0] l,
  input  logic [1:0]    modo,
  output logic          rco
);
  always_comb begin
    rco = 1'b0;
    unique case (modo)
      2'b00:   rco = &l;
      2'b01:   rco = (l == '0);
      2'b10:   rco = (l < LW'(3));
      default: rco = 1'b0;   // load never carries
    endcase
  end
endmodule

module contador_nbits_rco #(
  parameter int NIBBLES = 4,
  parameter int SLICE_W = 4
) (
  input  logic                clk,
  input  logic                reset_L,
  contador_nbits_rco_if.slave bus
);
  localparam int W = NIBBLES * SLICE_W;

  logic [W-1:0]       q_r, q_nxt;
  logic [NIBBLES-1:0] rco_r, rco_raw, rco_nxt;
  logic               ovf_r, ovf_nxt;
  logic               wrap;

  // Flags are computed from the pre-update count.
  for (genvar i = 0; i < NIBBLES; i++) begin : g_slice
    contador_rco_slice #(.LW((i + 1) * SLICE_W)) u_slice (
      .l    (q_r[(i + 1) * SLICE_W - 1:0]),
      .modo (bus.modo),
      .rco  (rco_raw[i])
    );
  end

  assign rco_nxt = bus.enb ? rco_raw : '0;
  // The top slice carrying is exactly a full-counter wrap.
  assign wrap    = rco_nxt[NIBBLES-1];

  always_comb begin
    q_nxt   = q_r;
    ovf_nxt = ovf_r;
    if (bus.enb) begin
      unique case (bus.modo)
        2'b00:   q_nxt = q_r + W'(1);
        2'b01:   q_nxt = q_r - W'(1);
        2'b10:   q_nxt = q_r - W'(3);
        default: begin
          q_nxt   = bus.D;
          ovf_nxt = 1'b0;
        end
      endcase
      if (wrap) begin
        ovf_nxt = 1'b1;
`ifdef CONTADOR_SATURATE_EN
        // Clamp at the end the count was heading towards.
        q_nxt = (bus.modo == 2'b00) ? '1 : '0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      q_r   <= '0;
      rco_r <= '0;
      ovf_r <= 1'b0;
    end else begin
      q_r   <= q_nxt;
      rco_r <= rco_nxt;
      ovf_r <= ovf_nxt;
    end
  end

  assign bus.Q   = q_r;
  assign bus.RCO = rco_r;
  assign bus.ovf = ovf_r;
endmodule

// File: doc/contador_nbits_rco.md
Name: contador_nbits_rco

Overview:
- Parametrised successor of the fixed 16-bit cascaded counter: one counter of NIBBLES×SLICE_W bits with per-slice ripple-carry-out flags.
- Adds a sticky overflow flag and an optional saturating mode.
- Drives the same probador-style benches and synthesises to the CMOS cell library as a drop-in for wider or narrower counters.
- Four operating modes selected by modo: count up, count down, count down by 3, parallel load.

Parameters:
- NIBBLES, 4, number of slices (RCO width); ≥1.
- SLICE_W, 4, bits per slice; ≥2.
- W, derived localparam = NIBBLES*SLICE_W, counter width; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- reset_L  in  1  asynchronous, active-low reset.
- enb  in  1  count/load enable.
- modo  in  2  operation select.
- D  in  W  parallel load value.
- Q  out  W  registered count.
- RCO  out  NIBBLES  registered per-slice carry/borrow pulse.
- ovf  out  1  sticky wrap flag.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Reset: reset_L=0 forces Q=0, RCO=0, ovf=0 immediately, regardless of clk. Reset mid-count discards the operation in progress. First update occurs on the first rising clk with reset_L=1.
- Latency: all outputs are registered. Effects of inputs sampled at edge n are visible after edge n.
- enb=0: Q and ovf hold; RCO=0.
- enb=1, modo=00 (up): Q ← Q+1 mod 2^W.
- enb=1, modo=01 (down): Q ← Q−1 mod 2^W.
- enb=1, modo=10 (down by 3): Q ← Q−3 mod 2^W.
- enb=1, modo=11 (load): Q ← D; RCO=0; ovf ← 0.
- RCO[i] is evaluated on the pre-update Q, with L_i = Q[(i+1)*SLICE_W−1:0]. It is set for exactly the one cycle after the update:
  - up: L_i all ones.
  - down: L_i == 0.
  - down by 3: L_i < 3.
  - Consequence: RCO is thermometer-shaped; RCO[i]=1 implies RCO[j]=1 for all j<i.
- RCO[NIBBLES−1]=1 marks a full-counter wrap. On that event ovf ← 1 and stays set until load or reset.
- Simultaneous load and wrap cannot occur (load never produces RCO).
- modo may change on any cycle; no internal state besides Q, RCO, ovf.

Optional Feature:
- Macro: CONTADOR_SATURATE_EN.
- Defined: an operation that would wrap clamps instead.
  - up at all-ones: Q stays all-ones.
  - down or down-by-3 when Q is below the step: Q ← 0.
  - RCO and ovf are computed exactly as in wrap mode; only Q differs.
- Undefined: modular wrap as in Behaviour; no saturation logic is synthesised.

Test Plan (NIBBLES=4, SLICE_W=4):
- Reset, load D=0x000E, modo=00 for 2 edges → Q=0x000F (RCO=0000), then Q=0x0010 (RCO=0001), ovf=0.
- Load 0xFFFF, modo=00 one edge → Q=0x0000, RCO=1111, ovf=1. Then load 0x1234 → Q=0x1234, ovf=0, RCO=0000.
- Load 0x0002, modo=10 one edge → Q=0xFFFF, RCO=1111, ovf=1. Then modo=01 one edge from 0x0100 (via load) → Q=0x00FF, RCO=0011.
- Q=0x00FF, enb=0 for 3 edges with modo=00 → Q holds 0x00FF, RCO=0000. Then enb=1 one edge → Q=0x0100, RCO=0011.
- Counting up from 0x0050, pull reset_L low between edges → Q=0, RCO=0, ovf=0 before the next edge. Release → counting resumes from 0x0001 on the first edge.
- With CONTADOR_SATURATE_EN: load 0xFFFF, up → Q=0xFFFF, RCO=1111, ovf=1. Load 0x0001, modo=10 → Q=0x0000, RCO=1111.
